// File: rtl/hack_debug_clock_ctrl.sv
// Debug clock controller for hack_soc bring-up: debounced run/step/select buttons drive a
// single-cycle SoC clock enable (free-run, pause, N-cycle step bursts) and an LED channel mux.
module hack_debug_clock_ctrl #(
  parameter int RUN_DIV_LOG2    = 14,
  parameter int STEP_COUNT      = 1,
  parameter int DEBOUNCE_CYCLES = 40,
  parameter int NUM_CHANNELS    = 4,
  parameter int LED_WIDTH       = 4,
  parameter int START_PAUSED    = 0,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      btn_run,
  input  logic                      btn_step,
  input  logic                      btn_sel,
  input  logic [16*NUM_CHANNELS-1:0] dbg_bus,
  output logic                      clk_en,
  output logic                      paused,
  output logic                      step_busy,
  output logic [CW-1:0]             chan_sel,
  output logic [LED_WIDTH-1:0]      led
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW  = RUN_DIV_LOG2 + 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]  PRESC_MAX = PW'((1 << RUN_DIV_LOG2) - 1);
  localparam logic [7:0]     STEP_LAST = 8'(STEP_COUNT - 1);

  typedef enum logic [1:0] {S_RUN, S_PAUSE, S_STEP} state_t;
  localparam state_t S_INIT = (START_PAUSED != 0) ? S_PAUSE : S_RUN;

  logic [2:0]          btn_raw;
  logic [2:0]          sync_p0, sync_p1, level, press;
  logic [2:0][DBW-1:0] db_cnt;
  logic                run_ev, step_ev, sel_ev;

  assign btn_raw = {btn_sel, btn_step, btn_run};
  assign run_ev  = press[0];
  assign step_ev = press[1];
  assign sel_ev  = press[2];

  // Stage p0/p1: two-flop synchroniser; then stability counter per button.
  // The counter only runs while the synced sample disagrees with the debounced level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      level   <= '0;
      press   <= '0;
      db_cnt  <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      for (int k = 0; k < 3; k++) begin
        press[k] <= 1'b0;
        if (sync_p1[k] == level[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          db_cnt[k] <= '0;
          level[k]  <= sync_p1[k];
          press[k]  <= sync_p1[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [7:0]    rem, rem_nx;
  logic          clk_en_nx;

  // rem holds the pulses still owed after the one currently on clk_en.
  always_comb begin
    state_nx  = state;
    presc_nx  = '0;
    rem_nx    = rem;
    clk_en_nx = 1'b0;
    case (state)
      S_RUN: begin
        if (run_ev) begin
          state_nx = S_PAUSE;
        end else if (presc == PRESC_MAX) begin
          clk_en_nx = 1'b1;
        end else begin
          presc_nx = presc + 1'b1;
        end
      end
      S_PAUSE: begin
        if (run_ev) begin
          state_nx = S_RUN;
        end else if (step_ev) begin
          state_nx  = S_STEP;
          rem_nx    = STEP_LAST;
          clk_en_nx = 1'b1;
        end
      end
      S_STEP: begin
        if (run_ev) begin
          state_nx = S_RUN;
        end else if (rem == 8'd0) begin
          state_nx = S_PAUSE;
        end else begin
          rem_nx    = rem - 1'b1;
          clk_en_nx = 1'b1;
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

  // Stage p2: state and all flag outputs registered together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_INIT;
      presc     <= '0;
      rem       <= '0;
      clk_en    <= 1'b0;
      paused    <= (START_PAUSED != 0);
      step_busy <= 1'b0;
    end else begin
      state     <= state_nx;
      presc     <= presc_nx;
      rem       <= rem_nx;
      clk_en    <= clk_en_nx;
      paused    <= (state_nx != S_RUN);
      step_busy <= (state_nx == S_STEP);
    end
  end

  logic [LED_WIDTH-1:0] led_nx;

  always_comb begin
    led_nx = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (chan_sel == CW'(k)) led_nx = dbg_bus[16*k +: LED_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chan_sel <= '0;
      led      <= '0;
    end else begin
      if (sel_ev) chan_sel <= (chan_sel == CW'(NUM_CHANNELS - 1)) ? '0 : chan_sel + 1'b1;
      led <= led_nx;
    end
  end

endmodule

// File: tb/tb_hack_debug_clock_ctrl.sv
// Scoreboard bench for hack_debug_clock_ctrl: expected clk_en pulses and channel changes are
// queued by the stimulus thread and popped by a negedge monitor whenever the DUT shows them.
module tb_hack_debug_clock_ctrl;

  localparam int END_CYC = 420;
  // Button raised in cycle c produces its press event in cycle c+6 (2 sync + 4 debounce).

  logic        clk = 1'b0;
  logic        reset_n, reset_n2;
  logic        btn_run, btn_step, btn_sel, btn_step2;
  logic [47:0] dbg_bus;
  logic        clk_en, paused, step_busy, clk_en2, paused2, step_busy2;
  logic [1:0]  chan_sel, chan_sel2;
  logic [3:0]  led, led2;

  hack_debug_clock_ctrl #(
    .RUN_DIV_LOG2(3), .STEP_COUNT(2), .DEBOUNCE_CYCLES(4),
    .NUM_CHANNELS(3), .LED_WIDTH(4), .START_PAUSED(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_run(btn_run), .btn_step(btn_step), .btn_sel(btn_sel),
    .dbg_bus(dbg_bus), .clk_en(clk_en), .paused(paused), .step_busy(step_busy),
    .chan_sel(chan_sel), .led(led)
  );

  hack_debug_clock_ctrl #(
    .RUN_DIV_LOG2(3), .STEP_COUNT(200), .DEBOUNCE_CYCLES(4),
    .NUM_CHANNELS(3), .LED_WIDTH(4), .START_PAUSED(1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n2), .btn_run(1'b0), .btn_step(btn_step2), .btn_sel(1'b0),
    .dbg_bus(dbg_bus), .clk_en(clk_en2), .paused(paused2), .step_busy(step_busy2),
    .chan_sel(chan_sel2), .led(led2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; logic busy; } en_t;
  typedef struct { int at; int chan; int led; } sel_t;
  en_t  q1[$], q2[$];
  sel_t qs[$];

  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push1(input int at, input logic busy);
    en_t e;
    e.at = at; e.busy = busy;
    q1.push_back(e);
  endtask

  task automatic push2(input int at, input logic busy);
    en_t e;
    e.at = at; e.busy = busy;
    q2.push_back(e);
  endtask

  task automatic push_sel(input int at, input int chan, input int l);
    sel_t s;
    s.at = at; s.chan = chan; s.led = l;
    qs.push_back(s);
  endtask

  // RUN entered in cycle 'entry' (prescaler 0 there) pulses every 8 cycles up to and including 'last'.
  task automatic push_run(input int entry, input int last);
    for (int t = entry + 8; t <= last; t += 8) push1(t, 1'b0);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor
  logic [1:0] prev_sel = 2'd0;
  bit         led_pend = 1'b0;
  int         led_exp  = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (clk_en) begin
        if (q1.size() == 0) begin
          check("dut clk_en unexpected", 1, 0);
        end else begin
          en_t e;
          e = q1.pop_front();
          check("dut clk_en cycle", cyc, e.at);
          check("dut step_busy at pulse", int'(step_busy), int'(e.busy));
        end
      end
      if (clk_en2) begin
        if (q2.size() == 0) begin
          check("dut2 clk_en unexpected", 1, 0);
        end else begin
          en_t e;
          e = q2.pop_front();
          check("dut2 clk_en cycle", cyc, e.at);
          check("dut2 step_busy at pulse", int'(step_busy2), int'(e.busy));
        end
      end
      if (led_pend) begin
        check("led after chan_sel change", int'(led), led_exp);
        led_pend = 1'b0;
      end
      if (chan_sel != prev_sel) begin
        if (qs.size() == 0) begin
          check("chan_sel change unexpected", int'(chan_sel), int'(prev_sel));
        end else begin
          sel_t s;
          s = qs.pop_front();
          check("chan_sel change cycle", cyc, s.at);
          check("chan_sel value", int'(chan_sel), s.chan);
          led_exp  = s.led;
          led_pend = 1'b1;
        end
      end
      prev_sel = chan_sel;
    end
  end

  initial begin
    reset_n = 1'b0; reset_n2 = 1'b0;
    btn_run = 1'b0; btn_step = 1'b0; btn_sel = 1'b0; btn_step2 = 1'b0;
    dbg_bus = {16'h000C, 16'h0005, 16'h0003};

    push_sel(207, 1, 4'h5);
    push_sel(237, 2, 4'hC);
    push_sel(267, 0, 4'h3);
    push_run(2, 66);

    // Reset held over edges 1 and 2
    wait_cyc(2);
    check("reset clk_en", int'(clk_en), 0);
    check("reset paused", int'(paused), 0);
    check("reset step_busy", int'(step_busy), 0);
    check("reset chan_sel", int'(chan_sel), 0);
    check("reset led", int'(led), 0);
    check("reset dut2 paused", int'(paused2), 1);
    reset_n = 1'b1; reset_n2 = 1'b1;

    wait_cyc(5);
    check("led ch0", int'(led), 3);
    check("dut2 led ch0", int'(led2), 3);
    wait_cyc(20);
    check("run paused", int'(paused), 0);

    // Short glitch on btn_run: no event
    wait_cyc(40); btn_run = 1'b1;
    wait_cyc(43); btn_run = 1'b0;
    wait_cyc(50);
    check("glitch paused", int'(paused), 0);

    // Real run press: event in cycle 66, PAUSE from 67
    wait_cyc(60); btn_run = 1'b1;
    wait_cyc(66);
    check("paused before event", int'(paused), 0);
    wait_cyc(67);
    check("paused after run press", int'(paused), 1);
    wait_cyc(72); btn_run = 1'b0;
    wait_cyc(167);
    check("pause held paused", int'(paused), 1);
    check("pause held step_busy", int'(step_busy), 0);

    // Step burst: event in 176, pulses 177..178
    push1(177, 1'b1);
    push1(178, 1'b1);
    wait_cyc(170); btn_step = 1'b1;
    wait_cyc(176);
    check("step_busy before burst", int'(step_busy), 0);
    wait_cyc(177);
    check("step_busy in burst", int'(step_busy), 1);
    check("paused in burst", int'(paused), 1);
    wait_cyc(179);
    check("step_busy after burst", int'(step_busy), 0);
    check("paused after burst", int'(paused), 1);
    wait_cyc(182); btn_step = 1'b0;

    // Channel select presses at 200, 230, 260
    for (int i = 0; i < 3; i++) begin
      wait_cyc(200 + 30*i); btn_sel = 1'b1;
      wait_cyc(212 + 30*i); btn_sel = 1'b0;
    end
    wait_cyc(290);
    check("paused after sel presses", int'(paused), 1);

    // Simultaneous run+step in PAUSE: run wins, RUN entered in 307
    push_run(307, END_CYC - 1);
    wait_cyc(300); btn_run = 1'b1; btn_step = 1'b1;
    wait_cyc(307);
    check("run+step paused", int'(paused), 0);
    check("run+step step_busy", int'(step_busy), 0);
    wait_cyc(312); btn_run = 1'b0; btn_step = 1'b0;

    // Long burst on dut2, reset during 3rd pulse (cycle 359)
    push2(357, 1'b1);
    push2(358, 1'b1);
    push2(359, 1'b1);
    wait_cyc(350); btn_step2 = 1'b1;
    wait_cyc(358); btn_step2 = 1'b0;
    check("dut2 step_busy in burst", int'(step_busy2), 1);
    wait_cyc(359); reset_n2 = 1'b0;
    wait_cyc(360); reset_n2 = 1'b1;
    check("dut2 clk_en after reset", int'(clk_en2), 0);
    check("dut2 step_busy after reset", int'(step_busy2), 0);
    check("dut2 paused after reset", int'(paused2), 1);

    wait_cyc(END_CYC);
    mon_en = 1'b0;
    @(negedge clk);
    check("dut pulses not seen", q1.size(), 0);
    check("dut2 pulses not seen", q2.size(), 0);
    check("chan_sel changes not seen", qs.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
